// File: rtl/controlador_transferencia_pkg.sv
// Shared definitions for the program loader and the BIOS controller.
// Holds the FSM state encoding, the default widths and the opcodes that both blocks decode.
package controlador_transferencia_pkg;

    localparam int DATA_WIDTH_PADRAO = 32;
    localparam int ADDR_WIDTH_PADRAO = 10;
    localparam int HD_AW_PADRAO      = 12;

    localparam logic [5:0] OPC_HALT  = 6'b111111;
    localparam logic [5:0] OPC_LI_RZ = 6'b001111;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        LE_TAM  = 3'd1,
        LE_PAL  = 3'd2,
        ESCREVE = 3'd3,
        FIM     = 3'd4
    } estado_t;

    function automatic logic eh_halt(input logic [5:0] opc);
        return (opc == OPC_HALT);
    endfunction

endpackage

// File: rtl/controlador_transferencia.sv
// Copies a length-prefixed program image from the HD into instruction memory,
// one word per read/write pair, then raises a sticky transfOK.
module controlador_transferencia
    import controlador_transferencia_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_PADRAO,
    parameter int ADDR_WIDTH = ADDR_WIDTH_PADRAO,
    parameter int HD_AW      = HD_AW_PADRAO
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [HD_AW-1:0]      hd_base,
    output logic                  hd_req,
    output logic [HD_AW-1:0]      hd_addr,
    input  logic                  hd_ack,
    input  logic [DATA_WIDTH-1:0] hd_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  transfOK,
    output logic                  erro
);

    localparam logic [DATA_WIDTH-1:0] CAPACIDADE = DATA_WIDTH'(1) << ADDR_WIDTH;
    localparam logic [HD_AW-1:0]      PTR_UM     = HD_AW'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_UM     = (ADDR_WIDTH + 1)'(1);

    estado_t               estado_r;
    logic [HD_AW-1:0]      ptr_r;
    logic [ADDR_WIDTH:0]   cnt_r;
    logic [ADDR_WIDTH:0]   n_r;
    logic [ADDR_WIDTH:0]   cnt_prox_s;

    assign cnt_prox_s = cnt_r + CNT_UM;

    // Transfer FSM; every output is a register updated on the state transition that needs it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_r <= OCIOSO;
            ptr_r    <= '0;
            cnt_r    <= '0;
            n_r      <= '0;
            hd_req   <= 1'b0;
            hd_addr  <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            transfOK <= 1'b0;
            erro     <= 1'b0;
        end else begin
            case (estado_r)
                OCIOSO: begin
                    if (start && !transfOK) begin
                        ptr_r    <= hd_base;
                        hd_addr  <= hd_base;
                        hd_req   <= 1'b1;
                        busy     <= 1'b1;
                        estado_r <= LE_TAM;
                    end
                end
                LE_TAM: begin
                    if (hd_ack) begin
                        n_r   <= hd_data[ADDR_WIDTH:0];
                        ptr_r <= ptr_r + PTR_UM;
                        if (hd_data > CAPACIDADE) begin
                            erro     <= 1'b1;
                            hd_req   <= 1'b0;
                            busy     <= 1'b0;
                            transfOK <= 1'b1;
                            estado_r <= FIM;
                        end else if (hd_data[ADDR_WIDTH:0] == '0) begin
                            hd_req   <= 1'b0;
                            busy     <= 1'b0;
                            transfOK <= 1'b1;
                            estado_r <= FIM;
                        end else begin
                            // hd_req stays high: the first word read starts right away
                            hd_addr  <= ptr_r + PTR_UM;
                            estado_r <= LE_PAL;
                        end
                    end
                end
                LE_PAL: begin
                    if (hd_ack) begin
                        mem_data <= hd_data;
                        mem_addr <= cnt_r[ADDR_WIDTH-1:0];
                        mem_we   <= 1'b1;
                        hd_req   <= 1'b0;
                        ptr_r    <= ptr_r + PTR_UM;
                        estado_r <= ESCREVE;
                    end
                end
                ESCREVE: begin
                    mem_we <= 1'b0;
                    cnt_r  <= cnt_prox_s;
                    if (cnt_prox_s == n_r) begin
                        busy     <= 1'b0;
                        transfOK <= 1'b1;
                        estado_r <= FIM;
                    end else begin
                        hd_req   <= 1'b1;
                        hd_addr  <= ptr_r;
                        estado_r <= LE_PAL;
                    end
                end
                FIM: begin
                    estado_r <= FIM;
                end
                default: begin
                    estado_r <= OCIOSO;
                    hd_req   <= 1'b0;
                    mem_we   <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_transferencia.sv
// Directed bench for the program loader: an HD responder with configurable wait states
// and a write monitor feed immediate-assertion checks against hand-computed images.
module tb_controlador_transferencia;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int HW = 12;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [HW-1:0] hd_base;
    logic          hd_req;
    logic [HW-1:0] hd_addr;
    logic          hd_ack;
    logic [DW-1:0] hd_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          busy;
    logic          transfOK;
    logic          erro;

    controlador_transferencia #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HD_AW(HW)) dut (
        .clock(clock), .reset(reset), .start(start), .hd_base(hd_base),
        .hd_req(hd_req), .hd_addr(hd_addr), .hd_ack(hd_ack), .hd_data(hd_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .transfOK(transfOK), .erro(erro)
    );

    initial forever #5 clock = ~clock;

    logic [DW-1:0] hd_mem [0:4095];
    logic [HW-1:0] ack_addrs [$];
    logic [AW-1:0] wr_a [$];
    logic [DW-1:0] wr_d [$];
    logic [HW-1:0] addr_req;
    int  ciclo = 0;
    int  atraso = 0;
    int  espera = 0;
    int  instab = 0;
    int  ack_ciclo = 0;
    int  ult_wr_ciclo = 0;
    int  passes = 0;
    int  total = 0;
    int  fim_ciclo;
    bit  hd_on = 1'b0;

    initial forever begin
        @(posedge clock);
        ciclo++;
    end

    // HD model: answers a request after `atraso` wait cycles and checks the request is held stable
    initial begin
        hd_ack  = 1'b0;
        hd_data = '0;
        forever begin
            @(negedge clock);
            if (!hd_on) begin
                hd_ack  = 1'($urandom);
                hd_data = $urandom;
                espera  = 0;
            end else begin
                hd_ack = 1'b0;
                if (hd_req !== 1'b1) begin
                    if (espera > 0) instab++;
                    espera = 0;
                end else begin
                    if (espera == 0) addr_req = hd_addr;
                    else if (hd_addr !== addr_req) instab++;
                    if (espera >= atraso) begin
                        hd_ack    = 1'b1;
                        hd_data   = hd_mem[hd_addr];
                        ack_addrs.push_back(hd_addr);
                        ack_ciclo = ciclo;
                        espera    = 0;
                    end else begin
                        espera++;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (mem_we === 1'b1) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_data);
            ult_wr_ciclo = ciclo;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        start = 1'b0;
        repeat (n) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic limpa();
        wr_a.delete();
        wr_d.delete();
        ack_addrs.delete();
        instab = 0;
    endtask

    task automatic carrega(input logic [HW-1:0] base, input logic [DW-1:0] cab,
                           input int k, input logic [DW-1:0] semente);
        hd_mem[base] = cab;
        for (int i = 0; i < k; i++) hd_mem[base + HW'(i + 1)] = semente + DW'(i);
    endtask

    task automatic executa(input logic [HW-1:0] base, input bit espia);
        hd_base   = base;
        start     = 1'b1;
        fim_ciclo = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clock);
            #1;
            if (espia && i == 0) begin
                chk("busy_on_accept", busy, 1);
                chk("req_on_accept", {hd_req, hd_addr}, {1'b1, base});
            end
            if (transfOK === 1'b1) begin
                fim_ciclo = ciclo;
                break;
            end
        end
        start = 1'b0;
        if (fim_ciclo < 0) chk("timeout_transfOK", transfOK, 1);
        @(negedge clock);
        #1;
    endtask

    task automatic confere(input string tag, input int n, input logic [DW-1:0] semente);
        chk({tag, "_strobes"}, wr_a.size(), n);
        for (int i = 0; i < n && i < wr_a.size(); i++)
            chk({tag, "_write"}, {wr_a[i], wr_d[i]}, {AW'(i), semente + DW'(i)});
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        hd_base = '0;
        for (int i = 0; i < 4096; i++) hd_mem[i] = '0;

        // 1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            start   = 1'($urandom);
            hd_base = HW'($urandom);
            @(negedge clock);
            chk("reset_outputs", {hd_req, hd_addr, mem_we, mem_addr, mem_data, busy, transfOK, erro}, 64'd0);
        end
        start = 1'b0;
        hd_on = 1'b1;
        reset = 1'b1;

        // 2: three words, ack in the first request cycle
        limpa();
        atraso = 0;
        carrega(12'h010, 32'd3, 3, 32'hA0A0_0000);
        executa(12'h010, 1'b1);
        confere("img3", 3, 32'hA0A0_0000);
        chk("img3_ok_latency", fim_ciclo - ult_wr_ciclo, 1);
        chk("img3_flags", {busy, erro, transfOK}, 3'b001);
        chk("img3_reads", ack_addrs.size(), 4);
        if (ack_addrs.size() == 4)
            chk("img3_read_addrs", {ack_addrs[0], ack_addrs[1], ack_addrs[2], ack_addrs[3]},
                {12'h010, 12'h011, 12'h012, 12'h013});
        chk("img3_stable", instab, 0);

        // start is ignored once the copy is finished
        start = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        start = 1'b0;
        chk("after_fim_idle", {hd_req, busy, 6'(wr_a.size())}, {1'b0, 1'b0, 6'd3});

        // 3: same image with four wait states per read
        do_reset(2);
        limpa();
        atraso = 4;
        executa(12'h010, 1'b0);
        confere("wait4", 3, 32'hA0A0_0000);
        chk("wait4_stable", instab, 0);
        chk("wait4_reads", ack_addrs.size(), 4);
        chk("wait4_flags", {busy, erro, transfOK}, 3'b001);

        // 4: empty image
        do_reset(2);
        limpa();
        atraso = 0;
        carrega(12'h020, 32'd0, 0, 32'h0);
        executa(12'h020, 1'b0);
        chk("n0_strobes", wr_a.size(), 0);
        chk("n0_ok_latency", fim_ciclo - ack_ciclo, 1);
        chk("n0_flags", {busy, erro, transfOK}, 3'b001);

        // 5: header one past capacity
        do_reset(2);
        limpa();
        carrega(12'h030, 32'd1025, 4, 32'h7700_0000);
        executa(12'h030, 1'b0);
        chk("over_strobes", wr_a.size(), 0);
        chk("over_flags", {busy, erro, transfOK}, 3'b011);

        // full capacity is legal
        do_reset(2);
        limpa();
        carrega(12'h100, 32'd1024, 1024, 32'h5000_0000);
        executa(12'h100, 1'b0);
        chk("full_strobes", wr_a.size(), 1024);
        if (wr_a.size() == 1024)
            chk("full_last", {wr_a[1023], wr_d[1023]}, {10'd1023, 32'h5000_03FF});
        chk("full_flags", {busy, erro, transfOK}, 3'b001);

        // HD pointer wraps modulo 2**HD_AW
        do_reset(2);
        limpa();
        carrega(12'hFFE, 32'd2, 2, 32'hC0DE_0000);
        executa(12'hFFE, 1'b0);
        confere("wrap", 2, 32'hC0DE_0000);
        if (ack_addrs.size() == 3)
            chk("wrap_addrs", {ack_addrs[0], ack_addrs[1], ack_addrs[2]}, {12'hFFE, 12'hFFF, 12'h000});
        else
            chk("wrap_reads", ack_addrs.size(), 3);

        // 6: reset after two of five words, then restart
        do_reset(2);
        limpa();
        carrega(12'h200, 32'd5, 5, 32'h6000_0000);
        hd_base = 12'h200;
        start   = 1'b1;
        for (int i = 0; i < 200 && wr_a.size() < 2; i++) begin
            @(negedge clock);
            #1;
        end
        chk("abort_two_written", wr_a.size(), 2);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            chk("abort_quiet", {hd_req, mem_we, busy, transfOK}, 4'b0000);
        end
        chk("abort_no_extra", wr_a.size(), 2);
        reset = 1'b1;
        limpa();
        executa(12'h200, 1'b0);
        confere("restart", 5, 32'h6000_0000);
        chk("restart_ok_latency", fim_ciclo - ult_wr_ciclo, 1);
        if (ack_addrs.size() > 0) chk("restart_base", ack_addrs[0], 12'h200);
        else chk("restart_reads", ack_addrs.size(), 6);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
